// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: PID validation, field counting and CRC qualification.
// Optional build macro USB_RX_LEN_CHECK_EN enables the per-type packet length rules.
module usb_rx_pkt_ctrl #(
    parameter int MAX_DATA = 64,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          eop,
    input  logic          rx_err,
    input  logic          crc_ok,
    output logic [7:0]    pid_o,
    output logic [2:0]    pkt_type,
    output logic          crc_sel,
    output logic          crc_clear,
    output logic          crc_shift,
    output logic          pay_valid,
    output logic [7:0]    pay_data,
    output logic [CW-1:0] byte_cnt,
    output logic          pkt_done,
    output logic          pkt_err,
    output logic [2:0]    err_code
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BODY  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam logic [2:0] T_TOKEN   = 3'b000;
    localparam logic [2:0] T_DATA    = 3'b001;
    localparam logic [2:0] T_HANDSHK = 3'b010;
    localparam logic [2:0] T_SPECIAL = 3'b011;
    localparam logic [2:0] T_INVALID = 3'b100;

    localparam logic [2:0] E_PID  = 3'b001;
    localparam logic [2:0] E_LEN  = 3'b010;
    localparam logic [2:0] E_CRC  = 3'b011;
    localparam logic [2:0] E_RX   = 3'b100;
    localparam logic [2:0] E_OVFL = 3'b101;

    localparam logic [CW-1:0] CNT_ZERO     = '0;
    localparam logic [CW-1:0] CNT_TWO      = CW'(2);
    localparam logic [CW-1:0] CNT_DATA_MAX = CW'(MAX_DATA + 2);
    localparam logic [CW-1:0] CNT_SAT      = '1;

    logic [2:0]    state_reg, state_next;
    logic [7:0]    pid_reg, pid_next;
    logic [2:0]    type_reg, type_next;
    logic          crc_sel_reg, crc_sel_next;
    logic          crc_clear_reg, crc_clear_next;
    logic          crc_shift_reg, crc_shift_next;
    logic          pay_valid_reg, pay_valid_next;
    logic [7:0]    pay_data_reg, pay_data_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    err_reg, err_next;
    logic          eop_seen_reg, eop_seen_next;
    logic          len_ok, len_check_en;
    logic [2:0]    pid_type;
    logic          pid_bad;

    function automatic logic [2:0] decode_type(input logic [3:0] p);
        if (p[2:0] == 3'b001)                      return T_TOKEN;
        else if (p[2:0] == 3'b011)                 return T_DATA;
        else if (p[2:0] == 3'b010)                 return T_HANDSHK;
        else if (p[1:0] == 2'b00 && p[3:2] != 2'b00) return T_SPECIAL;
        else                                       return T_INVALID;
    endfunction

`ifdef USB_RX_LEN_CHECK_EN
    assign len_check_en = 1'b1;
`else
    assign len_check_en = 1'b0;
`endif

    assign pid_type = decode_type(byte_data[3:0]);
    assign pid_bad  = (byte_data[7:4] != ~byte_data[3:0]) || (pid_type == T_INVALID);

    always_comb begin
        len_ok = 1'b0;
        case (type_reg)
            T_TOKEN:   len_ok = (cnt_reg == CNT_TWO);
            T_HANDSHK: len_ok = (cnt_reg == CNT_ZERO);
            T_DATA:    len_ok = (cnt_reg >= CNT_TWO) && (cnt_reg <= CNT_DATA_MAX);
            T_SPECIAL: len_ok = (cnt_reg == CNT_ZERO) || (cnt_reg == CNT_TWO);
            default:   len_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        pid_next       = pid_reg;
        type_next      = type_reg;
        crc_sel_next   = crc_sel_reg;
        crc_clear_next = 1'b0;
        crc_shift_next = 1'b0;
        pay_valid_next = 1'b0;
        pay_data_next  = pay_data_reg;
        cnt_next       = cnt_reg;
        err_next       = err_reg;
        eop_seen_next  = eop_seen_reg;
        case (state_reg)
            S_IDLE: begin
                if (byte_valid) begin
                    pid_next       = byte_data;
                    type_next      = pid_bad ? T_INVALID : pid_type;
                    crc_sel_next   = !pid_bad && (pid_type == T_DATA);
                    crc_clear_next = 1'b1;
                    cnt_next       = '0;
                    err_next       = 3'b000;
                    if (pid_bad) begin
                        state_next    = S_ERR;
                        err_next      = E_PID;
                        eop_seen_next = eop;
                    end else begin
                        state_next = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (rx_err) begin
                    state_next    = S_ERR;
                    err_next      = E_RX;
                    eop_seen_next = eop;
                end else if (byte_valid && cnt_reg == CNT_SAT) begin
                    state_next    = S_ERR;
                    err_next      = E_OVFL;
                    eop_seen_next = eop;
                end else begin
                    // A byte arriving alongside eop is counted before CHECK sees the length.
                    if (byte_valid) begin
                        cnt_next       = cnt_reg + 1'b1;
                        crc_shift_next = 1'b1;
                        if (type_reg == T_DATA) begin
                            pay_valid_next = 1'b1;
                            pay_data_next  = byte_data;
                        end
                    end
                    if (eop) state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                eop_seen_next = 1'b1;
                if (len_check_en && !len_ok) begin
                    state_next = S_ERR;
                    err_next   = E_LEN;
                end else if (cnt_reg != CNT_ZERO && !crc_ok) begin
                    state_next = S_ERR;
                    err_next   = E_CRC;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            // An eop landing in the ERR cycle itself also closes the packet.
            S_ERR:   state_next = (eop_seen_reg || eop) ? S_IDLE : S_DRAIN;
            S_DRAIN: if (eop) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pid_reg       <= 8'h00;
            type_reg      <= T_INVALID;
            crc_sel_reg   <= 1'b0;
            crc_clear_reg <= 1'b0;
            crc_shift_reg <= 1'b0;
            pay_valid_reg <= 1'b0;
            pay_data_reg  <= 8'h00;
            cnt_reg       <= '0;
            err_reg       <= 3'b000;
            eop_seen_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pid_reg       <= pid_next;
            type_reg      <= type_next;
            crc_sel_reg   <= crc_sel_next;
            crc_clear_reg <= crc_clear_next;
            crc_shift_reg <= crc_shift_next;
            pay_valid_reg <= pay_valid_next;
            pay_data_reg  <= pay_data_next;
            cnt_reg       <= cnt_next;
            err_reg       <= err_next;
            eop_seen_reg  <= eop_seen_next;
        end
    end

    assign pid_o     = pid_reg;
    assign pkt_type  = type_reg;
    assign crc_sel   = crc_sel_reg;
    assign crc_clear = crc_clear_reg;
    assign crc_shift = crc_shift_reg;
    assign pay_valid = pay_valid_reg;
    assign pay_data  = pay_data_reg;
    assign byte_cnt  = cnt_reg;
    assign err_code  = err_reg;
    assign pkt_done  = (state_reg == S_DONE);
    assign pkt_err   = (state_reg == S_ERR);
endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed self-checking bench for usb_rx_pkt_ctrl; expectations follow USB_RX_LEN_CHECK_EN.
module tb_usb_rx_pkt_ctrl;
    logic       clk = 1'b0;
    logic       rst, byte_valid, eop, rx_err, crc_ok;
    logic [7:0] byte_data;
    logic [7:0] pid_o, pay_data;
    logic [2:0] pkt_type, err_code;
    logic       crc_sel, crc_clear, crc_shift, pay_valid, pkt_done, pkt_err;
    logic [6:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int pay_cnt = 0;
    int base_a, base_b;

    usb_rx_pkt_ctrl #(.MAX_DATA(64), .CW(7)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .eop(eop), .rx_err(rx_err), .crc_ok(crc_ok), .pid_o(pid_o),
        .pkt_type(pkt_type), .crc_sel(crc_sel), .crc_clear(crc_clear),
        .crc_shift(crc_shift), .pay_valid(pay_valid), .pay_data(pay_data),
        .byte_cnt(byte_cnt), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_done)  done_cnt <= done_cnt + 1;
        if (pkt_err)   err_cnt  <= err_cnt + 1;
        if (pay_valid) pay_cnt  <= pay_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        byte_valid = 1'b1;
        byte_data  = b;
        eop        = e;
        tick();
        byte_valid = 1'b0;
        eop        = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; eop = 1'b0; rx_err = 1'b0; crc_ok = 1'b0;
        byte_data = 8'h00;
        tick(); tick();
        chk("rst_pid", 32'(pid_o), 32'h00);
        chk("rst_type", 32'(pkt_type), 32'h4);
        chk("rst_crc_sel", 32'(crc_sel), 0);
        chk("rst_cnt", 32'(byte_cnt), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_strobes", 32'({pkt_done, pkt_err, crc_clear, crc_shift, pay_valid}), 0);
        chk("rst_pay_data", 32'(pay_data), 0);
        rst = 1'b0;
        tick();

        // Token OUT, 2 bytes, good CRC
        crc_ok = 1'b1;
        send(8'hE1, 1'b0);
        chk("tok_pid", 32'(pid_o), 32'hE1);
        chk("tok_type", 32'(pkt_type), 0);
        chk("tok_crc_sel", 32'(crc_sel), 0);
        chk("tok_crc_clear", 32'(crc_clear), 1);
        send(8'h12, 1'b0);
        chk("tok_shift", 32'(crc_shift), 1);
        chk("tok_no_pay", 32'(pay_valid), 0);
        send(8'h34, 1'b0);
        chk("tok_cnt", 32'(byte_cnt), 2);
        pulse_eop();
        chk("tok_check_cycle", 32'({pkt_done, pkt_err}), 0);
        tick();
        chk("tok_done", 32'(pkt_done), 1);
        tick();
        chk("tok_done_one_cycle", 32'(pkt_done), 0);

        // DATA0, 6 bytes after PID, bad CRC
        crc_ok = 1'b0;
        base_a = pay_cnt;
        send(8'hC3, 1'b0);
        chk("d0_type", 32'(pkt_type), 1);
        chk("d0_crc_sel", 32'(crc_sel), 1);
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0);
        chk("d0_pay_data", 32'(pay_data), 32'h15);
        chk("d0_cnt", 32'(byte_cnt), 6);
        pulse_eop();
        tick();
        chk("d0_err", 32'(pkt_err), 1);
        chk("d0_err_code", 32'(err_code), 3);
        tick();
        chk("d0_pay_pulses", 32'(pay_cnt - base_a), 6);

        // Bad PID, drained until eop, then a handshake with ignored CRC
        send(8'hC2, 1'b0);
        chk("pid_err", 32'(pkt_err), 1);
        chk("pid_err_code", 32'(err_code), 1);
        tick();
        base_a = err_cnt;
        base_b = done_cnt;
        send(8'h11, 1'b0);
        rx_err = 1'b1;
        send(8'h22, 1'b0);
        rx_err = 1'b0;
        send(8'h33, 1'b1);
        tick();
        chk("drain_no_pulse", 32'((err_cnt - base_a) + (done_cnt - base_b)), 0);
        chk("err_code_held", 32'(err_code), 1);
        send(8'hD2, 1'b0);
        chk("ack_type", 32'(pkt_type), 2);
        chk("ack_err_cleared", 32'(err_code), 0);
        pulse_eop();
        tick();
        chk("ack_done_crc_ignored", 32'(pkt_done), 1);

        // ACK with an extra byte arriving together with eop
        crc_ok = 1'b1;
        tick();
        send(8'hD2, 1'b0);
        send(8'h55, 1'b1);
        chk("ack_extra_cnt", 32'(byte_cnt), 1);
        tick();
`ifdef USB_RX_LEN_CHECK_EN
        chk("ack_extra_err", 32'(pkt_err), 1);
        chk("ack_extra_code", 32'(err_code), 2);
`else
        chk("ack_extra_done", 32'(pkt_done), 1);
`endif
        tick();

        // DATA1 with rx_err after 3 bytes
        send(8'h4B, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        chk("d1_pay_valid", 32'(pay_valid), 1);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        chk("rx_err_pulse", 32'(pkt_err), 1);
        chk("rx_err_code", 32'(err_code), 4);
        tick();
        chk("rx_err_one_cycle", 32'(pkt_err), 0);
        pulse_eop();
        tick();

        // Reset in the middle of a data packet
        send(8'h4B, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        base_a = err_cnt + done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pid", 32'(pid_o), 0);
        chk("mid_rst_type", 32'(pkt_type), 4);
        chk("mid_rst_cnt", 32'(byte_cnt), 0);
        chk("mid_rst_pay", 32'({pay_valid, pay_data, crc_sel}), 0);
        pulse_eop();
        tick(); tick();
        chk("mid_rst_no_pulse", 32'(err_cnt + done_cnt - base_a), 0);

        // Data packet one byte over the maximum length
        send(8'hC3, 1'b0);
        for (int i = 0; i < 66; i++) send(8'(i), 1'b0);
        send(8'hEE, 1'b1);
        chk("long_cnt", 32'(byte_cnt), 67);
        tick();
`ifdef USB_RX_LEN_CHECK_EN
        chk("long_code", 32'(err_code), 2);
        chk("long_err", 32'(pkt_err), 1);
`else
        chk("long_done", 32'(pkt_done), 1);
`endif
        tick();

        // Data packet at exactly the maximum length
        send(8'hC3, 1'b0);
        for (int i = 0; i < 65; i++) send(8'(i), 1'b0);
        send(8'hEE, 1'b1);
        chk("max_cnt", 32'(byte_cnt), 66);
        tick();
        chk("max_done", 32'(pkt_done), 1);
        tick();

        // Counter saturation overflow
        send(8'hE1, 1'b0);
        for (int i = 0; i < 127; i++) send(8'(i), 1'b0);
        chk("sat_cnt", 32'(byte_cnt), 127);
        send(8'h77, 1'b0);
        chk("ovfl_err", 32'(pkt_err), 1);
        chk("ovfl_code", 32'(err_code), 5);
        tick();
        send(8'h78, 1'b0);
        pulse_eop();
        tick();

        // Token with bad CRC after recovering from drain
        crc_ok = 1'b0;
        send(8'hE1, 1'b0);
        chk("tok2_crc_clear", 32'(crc_clear), 1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        pulse_eop();
        tick();
        chk("tok2_err", 32'(pkt_err), 1);
        chk("tok2_code", 32'(err_code), 3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
